// File: rtl/alu_issue_if.sv
// alu_issue_if: issue, ALU operand/result, register-load and debug signals.
// master = instruction source / ALU / debug side, slave = alu_issue.
interface alu_issue_if;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_oc;
    logic [2:0] in_dst;
    logic [2:0] in_src1;
    logic [2:0] in_src2;
    logic [2:0] alu_oc;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_f;
    logic       ld_en;
    logic [2:0] ld_addr;
    logic [3:0] ld_data;
    logic [2:0] dbg_addr;
    logic [3:0] dbg_data;
    logic       done;
    logic       err;

    modport master (
        output in_valid, in_oc, in_dst, in_src1, in_src2,
        output alu_f, ld_en, ld_addr, ld_data, dbg_addr,
        input  in_ready, alu_oc, alu_a, alu_b,
        input  dbg_data, done, err
    );

    modport slave (
        input  in_valid, in_oc, in_dst, in_src1, in_src2,
        input  alu_f, ld_en, ld_addr, ld_data, dbg_addr,
        output in_ready, alu_oc, alu_a, alu_b,
        output dbg_data, done, err
    );
endinterface

// File: rtl/alu_issue.sv
// alu_issue: 8x4 register file plus IDLE/READ/EXEC/WB issue FSM that feeds
// a downstream combinational ALU and writes its result back.
// Ports: clk, rst (async, active high), bus (alu_issue_if.slave).
// Option: define ALU_ISSUE_DIV_TRAP_EN to trap divide-by-zero (err pulse,
// no writeback); otherwise err is 0 and the ALU result is written as-is.
module alu_issue #(
    parameter logic [3:0] RF_RESET_VAL = 4'h0
) (
    input  logic        clk,
    input  logic        rst,
    alu_issue_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    state_t     state;
    logic       rdy_q;
    logic       done_q;
    logic       err_q;
    logic [2:0] oc_q;
    logic [2:0] dst_q;
    logic [2:0] src1_q;
    logic [2:0] src2_q;
    logic [2:0] alu_oc_q;
    logic [3:0] alu_a_q;
    logic [3:0] alu_b_q;
    logic [3:0] res_q;
    logic [3:0] rf [8];
    logic       trap;

`ifdef ALU_ISSUE_DIV_TRAP_EN
    assign trap = (alu_oc_q == 3'b011) && (alu_b_q == 4'd0);
`else
    assign trap = 1'b0;
`endif

    assign bus.in_ready = rdy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.alu_oc   = alu_oc_q;
    assign bus.alu_a    = alu_a_q;
    assign bus.alu_b    = alu_b_q;
    assign bus.dbg_data = rf[bus.dbg_addr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rdy_q    <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            oc_q     <= 3'd0;
            dst_q    <= 3'd0;
            src1_q   <= 3'd0;
            src2_q   <= 3'd0;
            alu_oc_q <= 3'd0;
            alu_a_q  <= 4'd0;
            alu_b_q  <= 4'd0;
            res_q    <= 4'd0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state)
                IDLE: begin
                    // rdy_q is high in IDLE, so in_valid alone completes
                    // the handshake here.
                    if (bus.in_valid) begin
                        oc_q   <= bus.in_oc;
                        dst_q  <= bus.in_dst;
                        src1_q <= bus.in_src1;
                        src2_q <= bus.in_src2;
                        rdy_q  <= 1'b0;
                        state  <= READ;
                    end
                end
                READ: begin
                    alu_oc_q <= oc_q;
                    alu_a_q  <= rf[src1_q];
                    alu_b_q  <= rf[src2_q];
                    state    <= EXEC;
                end
                EXEC: begin
                    res_q  <= bus.alu_f;
                    done_q <= 1'b1;
                    err_q  <= trap;
                    state  <= WB;
                end
                WB: begin
                    rdy_q <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The writeback assignment comes last so it overrides a load to the
    // same address at the same edge. err_q is high only in a trapped WB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                rf[i] <= RF_RESET_VAL;
            end
        end else begin
            if (bus.ld_en) begin
                rf[bus.ld_addr] <= bus.ld_data;
            end
            if (state == WB && !err_q) begin
                rf[dst_q] <= res_q;
            end
        end
    end
endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
- REQ-001 SHALL have parameter RF_RESET_VAL, default 4'h0, the value every register-file entry takes on reset.
- REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
- REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
- REQ-004 SHALL have port in_valid, input, 1, instruction offered.
- REQ-005 SHALL have port in_ready, output, 1, block can accept an instruction.
- REQ-006 SHALL have port in_oc, input, 3, ALU opcode: 000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 NOT, 101 XOR, 110 OR, 111 AND.
- REQ-007 SHALL have ports in_dst, in_src1 and in_src2, each input, 3, register-file addresses.
- REQ-008 SHALL have ports alu_oc, alu_a and alu_b, outputs, 3/4/4, registered operands to the downstream combinational ALU.
- REQ-009 SHALL have port alu_f, input, 4, ALU result.
- REQ-010 SHALL have ports ld_en, ld_addr and ld_data, inputs, 1/3/4, external register load.
- REQ-011 SHALL have ports dbg_addr, input, 3, and dbg_data, output, 4, combinational register-file read.
- REQ-012 SHALL have port done, output, 1, one-cycle pulse on writeback.
- REQ-013 SHALL have port err, output, 1, one-cycle trap pulse (see Configuration).

Function
- REQ-014 SHALL contain an 8 x 4-bit register file.
- REQ-015 SHALL implement the FSM IDLE -> READ -> EXEC -> WB -> IDLE, one cycle per state except IDLE.
- REQ-016 in_ready SHALL be 1 only in IDLE; a handshake is in_valid && in_ready at a rising edge; it latches oc/dst/src1/src2 and moves to READ.
- REQ-017 in_valid while not in IDLE SHALL be ignored, with no latching and no side effects.
- REQ-018 In READ the block SHALL register alu_oc = latched oc, alu_a = rf[src1] and alu_b = rf[src2], using register contents as of the start of that cycle.
- REQ-019 In EXEC the block SHALL capture alu_f into an internal result register, with alu_* held stable.
- REQ-020 In WB the block SHALL write result to rf[dst] and assert done for exactly that cycle.
- REQ-021 Latency SHALL be: handshake at edge T, done high during cycle T+3, in_ready high again from edge T+4.
- REQ-022 alu_oc, alu_a and alu_b SHALL hold their last values outside READ.
- REQ-023 ld_en SHALL write ld_data to rf[ld_addr] in any state.
- REQ-024 If ld_en and the WB write target the same address in the same cycle, the WB write SHALL win; different addresses SHALL both be written.
- REQ-025 A ld write landing at the same edge that completes READ SHALL NOT be visible in that READ's operands.
- REQ-026 src1 == src2 and dst == src SHALL be legal; the writeback SHALL overwrite the source after the read.
- REQ-027 Result width SHALL be 4 bits; wrap and truncation are defined by the ALU and are not checked here.

Reset
- REQ-028 rst SHALL force, immediately and independent of clk: state IDLE, in_ready 1, done 0, err 0, alu_oc/alu_a/alu_b 0, result register 0, all rf entries RF_RESET_VAL.
- REQ-029 Reset mid-operation SHALL abort the operation with no writeback and no done.
- REQ-030 The first handshake SHALL be possible at the first rising edge after rst deasserts.

Configuration
- REQ-031 Macro ALU_ISSUE_DIV_TRAP_EN, when defined: if alu_oc == 011 and alu_b == 0, WB SHALL skip the rf write and pulse err together with done.
- REQ-032 When ALU_ISSUE_DIV_TRAP_EN is undefined: err SHALL be tied 0, and divide-by-zero SHALL write alu_f unmodified.

Verification
- REQ-033 Load r1 = 3 and r2 = 5, issue ADD dst = r0 -> done at T+3, dbg r0 = 8, alu_a = 3, alu_b = 5.
- REQ-034 r1 = 2, issue SUB r3 = r1 - r1 -> r3 = 0; then MUL r4 = r2(5) * r2 -> r4 = 9 (25 mod 16).
- REQ-035 Hold in_valid high continuously for two instructions -> second accepted exactly at T+4, none dropped or duplicated.
- REQ-036 ld_en to r0 = 7 coincident with WB to r0 = 8 -> r0 = 8; same-cycle ld to r5 = 7 -> r5 = 7.
- REQ-037 With macro defined: r6 = 9, r7 = 0, DIV r1 = r6 / r7 -> err and done pulse together, r1 unchanged; without macro, err stays 0.
- REQ-038 Assert rst during EXEC -> in_ready 1 immediately, no done, dbg of all registers = RF_RESET_VAL.
